// File: rtl/vga_pkg.sv
// Shared VGA timing constants and sync decoder state encoding.
package vga_pkg;

    // 640x480 @ 60 Hz reference timing (pixels / lines)
    localparam int HD = 640;
    localparam int HF = 48;
    localparam int HB = 16;
    localparam int HR = 96;
    localparam int VD = 480;
    localparam int VF = 10;
    localparam int VB = 33;
    localparam int VR = 2;

    localparam int H_TOTAL = HD + HF + HB + HR;  // 800
    localparam int V_TOTAL = VD + VF + VB + VR;  // 525

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } sync_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Polarity-normalising sync edge detector, qualified by the pixel tick.
module sync_edge_det #(
    parameter bit POL = 1'b1
) (
    input  logic CLK_100MHz,
    input  logic reset,
    input  logic p_tick,
    input  logic sync_in,
    output logic asserted_edge
);

    logic norm;
    logic prev;

    assign norm = (sync_in == POL);

    // History of the normalised level, updated only on pixel ticks
    always_ff @(posedge CLK_100MHz) begin
        if (reset) begin
            prev <= 1'b0;
        end else if (p_tick) begin
            prev <= norm;
        end
    end

    assign asserted_edge = p_tick && norm && !prev;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and line/frame timing from a hsync/vsync/video_on stream.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_SEARCH  | no timing reference; waiting for a vsync edge
// ST_MEASURE | one frame of measurement; every line must match the first
// ST_LOCKED  | h_total/v_total valid; any deviation drops back to search
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int H_MAX     = 2047,
    parameter int V_MAX     = 1023
) (
    input  logic        CLK_100MHz,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        video_on,
    output logic        pixel_valid,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] h_total,
    output logic [9:0]  v_total,
    output logic        err
);

    localparam logic [10:0] H_SAT = 11'(H_MAX);
    localparam logic [9:0]  V_SAT = 10'(V_MAX);

    logic        h_edge;
    logic        v_edge;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic [9:0]  x_cnt;
    logic [9:0]  y_cnt;
    logic        had_video;
    logic [9:0]  x_now;
    logic [9:0]  y_now;
    logic        sat_hit;
    logic [10:0] ref_h;
    logic        ref_valid;
    sync_state_t state;

    sync_edge_det #(.POL(HSYNC_POL)) u_hsync_edge (
        .CLK_100MHz    (CLK_100MHz),
        .reset         (reset),
        .p_tick        (p_tick),
        .sync_in       (hsync),
        .asserted_edge (h_edge)
    );

    sync_edge_det #(.POL(VSYNC_POL)) u_vsync_edge (
        .CLK_100MHz    (CLK_100MHz),
        .reset         (reset),
        .p_tick        (p_tick),
        .sync_in       (vsync),
        .asserted_edge (v_edge)
    );

    // Coordinates of the pixel in this tick, with the edge resets applied first
    assign x_now = h_edge ? 10'd0 : x_cnt;
    assign y_now = v_edge ? 10'd0 : ((h_edge && had_video) ? y_cnt + 10'd1 : y_cnt);

    // Saturation is reported only on the tick that reaches the limit, not while stuck there
    assign sat_hit = p_tick && ((!h_edge && (h_cnt == H_SAT - 11'd1)) ||
                                (h_edge && !v_edge && (v_cnt == V_SAT - 10'd1)));

    // Position counters: tick count within the line, line count within the frame, active x/y
    always_ff @(posedge CLK_100MHz) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            had_video <= 1'b0;
        end else if (p_tick) begin
            if (h_edge) begin
                h_cnt <= 11'd1;
            end else if (h_cnt != H_SAT) begin
                h_cnt <= h_cnt + 11'd1;
            end

            if (v_edge) begin
                v_cnt <= '0;
            end else if (h_edge && (v_cnt != V_SAT)) begin
                v_cnt <= v_cnt + 10'd1;
            end

            x_cnt <= x_now + {9'd0, video_on};
            y_cnt <= y_now;

            if (h_edge || v_edge) begin
                had_video <= video_on;
            end else begin
                had_video <= had_video | video_on;
            end
        end
    end

    // Registered pixel and sync-edge outputs
    always_ff @(posedge CLK_100MHz) begin
        if (reset) begin
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_valid <= p_tick && video_on;
            line_start  <= h_edge;
            frame_start <= v_edge;
            if (p_tick && video_on) begin
                pixel_x <= x_now;
                pixel_y <= y_now;
            end
        end
    end

    // Lock FSM: h_cnt at an hsync edge still holds the length of the line just ended
    always_ff @(posedge CLK_100MHz) begin
        if (reset) begin
            state     <= ST_SEARCH;
            locked    <= 1'b0;
            err       <= 1'b0;
            h_total   <= '0;
            v_total   <= '0;
            ref_h     <= '0;
            ref_valid <= 1'b0;
        end else begin
            err <= 1'b0;
            if (p_tick) begin
                if (sat_hit) begin
                    err    <= 1'b1;
                    locked <= 1'b0;
                    state  <= ST_SEARCH;
                end else begin
                    case (state)
                        ST_SEARCH: begin
                            if (v_edge) begin
                                ref_h     <= '0;
                                ref_valid <= 1'b0;
                                state     <= ST_MEASURE;
                            end
                        end
                        ST_MEASURE: begin
                            if (h_edge && ref_valid && (h_cnt != ref_h)) begin
                                err   <= 1'b1;
                                state <= ST_SEARCH;
                            end else begin
                                if (h_edge && !ref_valid) begin
                                    ref_h     <= h_cnt;
                                    ref_valid <= 1'b1;
                                end
                                if (v_edge && ref_valid) begin
                                    h_total <= ref_h;
                                    v_total <= v_cnt + 10'd1;
                                    locked  <= 1'b1;
                                    state   <= ST_LOCKED;
                                end
                            end
                        end
                        ST_LOCKED: begin
                            if ((h_edge && (h_cnt != h_total)) ||
                                (v_edge && ((v_cnt + 10'd1) != v_total))) begin
                                err    <= 1'b1;
                                locked <= 1'b0;
                                state  <= ST_SEARCH;
                            end
                        end
                        default: begin
                            locked <= 1'b0;
                            state  <= ST_SEARCH;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a small 12x6 timing:
// active 8x4, hsync at h 9-10, vsync edge aligned to the hsync edge of line 4.
module tb_vga_sync_decoder;

    logic        CLK_100MHz = 1'b0;
    logic        reset;
    logic        p_tick;
    logic        hsync, vsync, video_on;
    logic        hsync_n, vsync_n;

    logic        pixel_valid, line_start, frame_start, locked, err;
    logic [9:0]  pixel_x, pixel_y, v_total;
    logic [10:0] h_total;

    logic        pixel_valid2, line_start2, frame_start2, locked2, err2;
    logic [9:0]  pixel_x2, pixel_y2, v_total2;
    logic [10:0] h_total2;

    int errors = 0;
    int checks = 0;

    int err_seen, err2_seen, pv_seen, ls_seen, fs_seen;
    int first_x, first_y, last_x, last_y;
    bit got_first;
    int tick_no, first_err_tick;

    always #5 CLK_100MHz = ~CLK_100MHz;

    vga_sync_decoder dut (
        .CLK_100MHz (CLK_100MHz), .reset (reset), .p_tick (p_tick),
        .hsync (hsync), .vsync (vsync), .video_on (video_on),
        .pixel_valid (pixel_valid), .pixel_x (pixel_x), .pixel_y (pixel_y),
        .line_start (line_start), .frame_start (frame_start), .locked (locked),
        .h_total (h_total), .v_total (v_total), .err (err)
    );

    vga_sync_decoder #(.HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) dut_inv (
        .CLK_100MHz (CLK_100MHz), .reset (reset), .p_tick (p_tick),
        .hsync (hsync_n), .vsync (vsync_n), .video_on (video_on),
        .pixel_valid (pixel_valid2), .pixel_x (pixel_x2), .pixel_y (pixel_y2),
        .line_start (line_start2), .frame_start (frame_start2), .locked (locked2),
        .h_total (h_total2), .v_total (v_total2), .err (err2)
    );

    function automatic logic hs_of(input int h);
        return (h >= 9) && (h <= 10);
    endfunction

    function automatic logic vs_of(input int v, input int h);
        return ((v == 4) && (h >= 9)) || ((v == 5) && (h < 9));
    endfunction

    function automatic logic vid_of(input int v, input int h);
        return (h < 8) && (v < 4);
    endfunction

    task automatic clear_mon();
        err_seen = 0; err2_seen = 0; pv_seen = 0; ls_seen = 0; fs_seen = 0;
        got_first = 0; first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        first_err_tick = -1;
    endtask

    task automatic sample();
        if (err) begin
            err_seen++;
            if (first_err_tick < 0) first_err_tick = tick_no;
        end
        if (err2) err2_seen++;
        if (line_start) ls_seen++;
        if (frame_start) fs_seen++;
        if (pixel_valid) begin
            pv_seen++;
            if (!got_first) begin
                got_first = 1;
                first_x = int'(pixel_x);
                first_y = int'(pixel_y);
            end
            last_x = int'(pixel_x);
            last_y = int'(pixel_y);
        end
    endtask

    // One pixel tick followed by one idle clock carrying inverted (ignored) inputs
    task automatic tick(input logic h, input logic v, input logic vid);
        p_tick = 1'b1; hsync = h; vsync = v; video_on = vid;
        hsync_n = ~h; vsync_n = ~v;
        tick_no++;
        @(posedge CLK_100MHz); #1; sample();
        p_tick = 1'b0; hsync = ~h; vsync = ~v; video_on = ~vid;
        hsync_n = h; vsync_n = v;
        @(posedge CLK_100MHz); #1; sample();
    endtask

    task automatic send_ticks(input int v, input int h_from, input int h_to);
        for (int h = h_from; h <= h_to; h++) tick(hs_of(h), vs_of(v, h), vid_of(v, h));
    endtask

    task automatic send_frame();
        for (int v = 0; v < 6; v++) send_ticks(v, 0, 11);
    endtask

    task automatic test_reset();
        reset = 1'b1; p_tick = 1'b1; hsync = 1'b1; vsync = 1'b1; video_on = 1'b1;
        hsync_n = 1'b0; vsync_n = 1'b0;
        repeat (2) @(posedge CLK_100MHz);
        #1;
        checks++;
        if ({pixel_valid, pixel_x, pixel_y} !== 21'd0) begin
            errors++; $display("FAIL reset_pixel: got %b/%0d/%0d want 0/0/0", pixel_valid, pixel_x, pixel_y);
        end
        checks++;
        if ({line_start, frame_start, err, locked} !== 4'd0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {line_start, frame_start, err, locked});
        end
        checks++;
        if ({h_total, v_total} !== 21'd0 || locked2 !== 1'b0) begin
            errors++; $display("FAIL reset_totals: got h=%0d v=%0d locked2=%b want 0 0 0", h_total, v_total, locked2);
        end
        reset = 1'b0; p_tick = 1'b0;
        @(posedge CLK_100MHz); #1;
    endtask

    task automatic test_lock();
        clear_mon();
        send_frame();
        send_ticks(0, 0, 11); send_ticks(1, 0, 11); send_ticks(2, 0, 11); send_ticks(3, 0, 11);
        send_ticks(4, 0, 8);
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL lock_early: locked=%b want 0 before second vsync edge", locked);
        end
        send_ticks(4, 9, 9);
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL lock_rise: locked=%b want 1 after second vsync edge", locked);
        end
        send_ticks(4, 10, 11); send_ticks(5, 0, 11);
        checks++;
        if (h_total !== 11'd12 || v_total !== 10'd6) begin
            errors++; $display("FAIL lock_totals: got h=%0d v=%0d want 12 6", h_total, v_total);
        end
        checks++;
        if (err_seen != 0) begin
            errors++; $display("FAIL lock_no_err: got %0d err pulses want 0", err_seen);
        end
    endtask

    task automatic test_inverted_polarity();
        clear_mon();
        send_frame();
        checks++;
        if (locked2 !== 1'b1 || h_total2 !== 11'd12 || v_total2 !== 10'd6) begin
            errors++; $display("FAIL inv_pol_lock: got locked=%b h=%0d v=%0d want 1 12 6", locked2, h_total2, v_total2);
        end
        checks++;
        if (err2_seen != 0) begin
            errors++; $display("FAIL inv_pol_err: got %0d err pulses want 0", err2_seen);
        end
    endtask

    task automatic test_pixels();
        clear_mon();
        send_frame();
        checks++;
        if (pv_seen != 32) begin
            errors++; $display("FAIL pixel_count: got %0d want 32", pv_seen);
        end
        checks++;
        if (first_x != 0 || first_y != 0 || last_x != 7 || last_y != 3) begin
            errors++; $display("FAIL pixel_corners: got first (%0d,%0d) last (%0d,%0d) want (0,0) (7,3)", first_x, first_y, last_x, last_y);
        end
        checks++;
        if (fs_seen != 1 || ls_seen != 6) begin
            errors++; $display("FAIL sync_pulses: got frame_start=%0d line_start=%0d want 1 6", fs_seen, ls_seen);
        end
        checks++;
        if (err_seen != 0 || locked !== 1'b1) begin
            errors++; $display("FAIL pixel_locked: got err=%0d locked=%b want 0 1", err_seen, locked);
        end
    endtask

    task automatic test_short_line();
        clear_mon();
        send_ticks(0, 0, 11);
        send_ticks(1, 0, 10);
        send_ticks(2, 0, 8);
        checks++;
        if (err_seen != 0 || locked !== 1'b1) begin
            errors++; $display("FAIL short_pre: got err=%0d locked=%b want 0 1", err_seen, locked);
        end
        send_ticks(2, 9, 9);
        checks++;
        if (err_seen != 1 || locked !== 1'b0) begin
            errors++; $display("FAIL short_err: got err=%0d locked=%b want 1 0", err_seen, locked);
        end
        send_ticks(2, 10, 11); send_ticks(3, 0, 11); send_ticks(4, 0, 11); send_ticks(5, 0, 11);
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL short_one_vsync: locked=%b want 0 after one vsync edge", locked);
        end
        send_frame();
        checks++;
        if (locked !== 1'b1 || err_seen != 1) begin
            errors++; $display("FAIL short_relock: got locked=%b err=%0d want 1 1", locked, err_seen);
        end
    endtask

    task automatic test_saturation();
        int start;
        clear_mon();
        start = tick_no;
        for (int i = 0; i < 2100; i++) tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (err_seen != 1 || err2_seen != 1) begin
            errors++; $display("FAIL sat_err_once: got err=%0d err_inv=%0d want 1 1", err_seen, err2_seen);
        end
        checks++;
        if (first_err_tick - start != 2044) begin
            errors++; $display("FAIL sat_err_tick: got tick %0d want 2044", first_err_tick - start);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL sat_unlocked: locked=%b want 0", locked);
        end
        send_frame();
        send_frame();
        checks++;
        if (locked !== 1'b1 || err_seen != 1) begin
            errors++; $display("FAIL sat_relock: got locked=%b err=%0d want 1 1", locked, err_seen);
        end
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        send_ticks(0, 0, 11); send_ticks(1, 0, 11); send_ticks(2, 0, 3);
        reset = 1'b1; p_tick = 1'b1; hsync = 1'b0; vsync = 1'b0; video_on = 1'b1;
        hsync_n = 1'b1; vsync_n = 1'b1;
        @(posedge CLK_100MHz); #1;
        checks++;
        if ({pixel_valid, line_start, frame_start, locked, err} !== 5'd0 ||
            {pixel_x, pixel_y, h_total, v_total} !== 41'd0) begin
            errors++; $display("FAIL midreset_outputs: got pv=%b x=%0d y=%0d lock=%b h=%0d v=%0d want all 0",
                               pixel_valid, pixel_x, pixel_y, locked, h_total, v_total);
        end
        reset = 1'b0;
        send_ticks(2, 4, 11); send_ticks(3, 0, 11); send_ticks(4, 0, 11); send_ticks(5, 0, 11);
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL midreset_one_vsync: locked=%b want 0", locked);
        end
        send_frame();
        checks++;
        if (locked !== 1'b1 || h_total !== 11'd12 || v_total !== 10'd6) begin
            errors++; $display("FAIL midreset_relock: got locked=%b h=%0d v=%0d want 1 12 6", locked, h_total, v_total);
        end
    endtask

    initial begin
        tick_no = 0;
        reset = 1'b1; p_tick = 1'b0; hsync = 1'b0; vsync = 1'b0; video_on = 1'b0;
        hsync_n = 1'b1; vsync_n = 1'b1;
        clear_mon();
        test_reset();
        test_lock();
        test_inverted_polarity();
        test_pixels();
        test_short_line();
        test_saturation();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
